fp_mul_norm_round: RTL

- Final normalize-and-round stage of the single-precision floating-point multiplier.
- Consumes the registered 48-bit mantissa product, sign and 9-bit exponent from the add/normalize pipeline register.
- Produces a packed IEEE-754 binary32 result plus exception flags.
- Two-stage pipeline with valid/ready flow control, so the multiplier can be back-pressured by its consumer.

---
 rtl/fp_mul_norm_round.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fp_mul_norm_round.sv
// Final normalize/round/pack stage of the binary32 multiplier.
// Two registered stages (S1 normalize, S2 round+pack) with valid/ready flow control.
module fp_mul_norm_round #(
  parameter bit RNE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] c,
  input  logic        sign_in,
  input  logic [8:0]  exp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_advance;
  logic accept;
  logic s2_load;

  always_comb begin
    s1_advance = ~s2_valid_q | out_ready;
    in_ready   = ~s1_valid_q | s1_advance;
    accept     = in_valid & in_ready;
    s2_load    = s1_valid_q & s1_advance;
    s1_valid_d = accept | (s1_valid_q & ~s1_advance);
    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // S1 normalize: a product in [2,4) shifts right by one and bumps the exponent.
  logic [22:0] norm_m;
  logic        norm_g;
  logic        norm_s;
  logic [9:0]  norm_e;

  always_comb begin
    if (c[47]) begin
      norm_m = c[46:24];
      norm_g = c[23];
      norm_s = |c[22:0];
      norm_e = {1'b0, exp_in} + 10'd1;
    end else begin
      norm_m = c[45:23];
      norm_g = c[22];
      norm_s = |c[21:0];
      norm_e = {1'b0, exp_in};
    end
  end

  logic [22:0] s1_m_q;
  logic        s1_g_q;
  logic        s1_s_q;
  logic [9:0]  s1_e_q;
  logic        s1_zero_q;
  logic        s1_sign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_m_q     <= '0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_e_q     <= '0;
      s1_zero_q  <= 1'b0;
      s1_sign_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_m_q    <= norm_m;
        s1_g_q    <= norm_g;
        s1_s_q    <= norm_s;
        s1_e_q    <= norm_e;
        s1_zero_q <= (c == 48'd0);
        s1_sign_q <= sign_in;
      end
    end
  end

  // S2 round: a carry out of the fraction renormalizes to 1.0 and bumps the exponent.
  logic        rnd_inc;
  logic [23:0] rnd_m2;
  logic        rnd_carry;
  logic [22:0] rnd_frac;
  logic [9:0]  rnd_e;

  always_comb begin
    rnd_inc   = RNE & s1_g_q & (s1_s_q | s1_m_q[0]);
    rnd_m2    = {1'b0, s1_m_q} + {23'd0, rnd_inc};
    rnd_carry = rnd_m2[23];
    rnd_frac  = rnd_carry ? 23'd0 : rnd_m2[22:0];
    rnd_e     = s1_e_q + {9'd0, rnd_carry};
  end

  // S2 pack, zero first, then overflow, then flush-to-zero, then normal.
  logic [31:0] pack_result;
  logic        pack_ovf;
  logic        pack_unf;
  logic        pack_inx;

  always_comb begin
    pack_result = {s1_sign_q, 31'd0};
    pack_ovf    = 1'b0;
    pack_unf    = 1'b0;
    pack_inx    = 1'b0;
    if (s1_zero_q) begin
      pack_result = {s1_sign_q, 31'd0};
    end else if (rnd_e >= 10'd255) begin
      pack_result = {s1_sign_q, 8'hFF, 23'd0};
      pack_ovf    = 1'b1;
      pack_inx    = 1'b1;
    end else if (rnd_e == 10'd0) begin
      pack_result = {s1_sign_q, 31'd0};
      pack_unf    = 1'b1;
      pack_inx    = 1'b1;
    end else begin
      pack_result = {s1_sign_q, rnd_e[7:0], rnd_frac};
      pack_inx    = s1_g_q | s1_s_q;
    end
  end

  logic [31:0] result_q;
  logic        overflow_q;
  logic        underflow_q;
  logic        inexact_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        result_q    <= pack_result;
        overflow_q  <= pack_ovf;
        underflow_q <= pack_unf;
        inexact_q   <= pack_inx;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

endmodule
